// File: rtl/fc_buf_pkg.sv
// Shared types for the FC ReLU ping-pong frame buffer.
package fc_buf_pkg;
  localparam int DATA_W    = 14;
  localparam int NUM_BANKS = 2;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic                     bank_t;
endpackage

// File: rtl/fc_frame_bank.sv
// One bank of the ping-pong buffer: M-entry register array with a single
// write port, an asynchronous read port and a full flag with set/clear.
module fc_frame_bank
  import fc_buf_pkg::*;
#(
  parameter int M     = 17,
  parameter int WIDTH = DATA_W,
  parameter int IDX_W = $clog2(M)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic signed [WIDTH-1:0] rd_data,
  input  logic                    set_full,
  input  logic                    clr_full,
  output logic                    full
);

  logic signed [WIDTH-1:0] mem_q [M];
  logic signed [WIDTH-1:0] mem_d [M];
  logic                    full_q;
  logic                    full_d;

  // Next-state for storage and the full flag. Set and clear never target the
  // same bank in one cycle: set only happens while filling (not full), clear
  // only while draining (full).
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
    full_d = full_q;
    if (clr_full) full_d = 1'b0;
    if (set_full) full_d = 1'b1;
  end

  // Storage needs no reset: its contents are only observed while full is set.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Full flag, cleared by reset so reset discards any stored frame.
  always_ff @(posedge clk) begin
    if (reset) full_q <= 1'b0;
    else       full_q <= full_d;
  end

  assign rd_data = mem_q[rd_idx];
  assign full    = full_q;

endmodule

// File: rtl/fc_relu_frame_buffer.sv
// Ping-pong frame buffer behind an FC layer: applies ReLU on entry, stores
// whole M-element frames in two alternating banks and replays each frame
// with out_last on its final element.
// Optional feature: define FC_RELU_EN to clamp negative inputs to zero;
// without it values are stored unmodified.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// in_ready and out_valid depend only on registered state, never on inputs.
module fc_relu_frame_buffer
  import fc_buf_pkg::*;
#(
  parameter int M     = 17,
  parameter int WIDTH = DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_last
);

  localparam int                IDX_W    = $clog2(M);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(M - 1);

  bank_t            wr_bank_q, wr_bank_d;
  bank_t            rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             alive_q;

  logic [NUM_BANKS-1:0]    full;
  logic [NUM_BANKS-1:0]    wr_en;
  logic [NUM_BANKS-1:0]    set_full;
  logic [NUM_BANKS-1:0]    clr_full;
  logic signed [WIDTH-1:0] rd_data [NUM_BANKS];
  logic signed [WIDTH-1:0] wr_data;
  logic                    wr_fire;
  logic                    rd_fire;

  function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] x);
`ifdef FC_RELU_EN
    // Sign bit only, so the most negative value also maps to zero.
    return x[WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // alive_q keeps in_ready low during the reset cycle itself, when the full
  // flags may not yet hold their cleared value.
  assign in_ready  = alive_q && !full[wr_bank_q];
  assign out_valid = full[rd_bank_q];
  assign out_data  = out_valid ? rd_data[rd_bank_q] : '0;
  assign out_last  = out_valid && (rd_idx_q == LAST_IDX);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign wr_data   = relu(in_data);

  // Per-bank write strobes and full set/clear derived from the pointers.
  always_comb begin
    wr_en    = '0;
    set_full = '0;
    clr_full = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_en[b]    = wr_fire && (wr_bank_q == bank_t'(b));
      set_full[b] = wr_en[b] && (wr_idx_q == LAST_IDX);
      clr_full[b] = rd_fire && (rd_bank_q == bank_t'(b)) && (rd_idx_q == LAST_IDX);
    end
  end

  // Write and read pointer advance; each wraps and flips bank at frame end.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire) begin
      if (wr_idx_q == LAST_IDX) begin
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
    if (rd_fire) begin
      if (rd_idx_q == LAST_IDX) begin
        rd_idx_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end
  end

  // Pointer and alive registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      alive_q   <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      alive_q   <= 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    fc_frame_bank #(
      .M     (M),
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[b]),
      .wr_idx   (wr_idx_q),
      .wr_data  (wr_data),
      .rd_idx   (rd_idx_q),
      .rd_data  (rd_data[b]),
      .set_full (set_full[b]),
      .clr_full (clr_full[b]),
      .full     (full[b])
    );
  end

endmodule

// File: tb/tb_fc_relu_frame_buffer.sv
// Self-checking bench for fc_relu_frame_buffer. The reference model counts
// accepted and drained elements since reset: a frame is available once all
// its M elements are in, and the writer may proceed while fewer than two
// complete frames are waiting.
module tb_fc_relu_frame_buffer;

  localparam int M = 17;
  localparam int W = 14;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic                out_last;

  fc_relu_frame_buffer #(.M(M), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic signed [W-1:0] exp_q[$];
  int acc_n;
  int dr_n;
  bit alive;
  int n_checks;
  int n_errors;
  int phase_acc;
  int phase_stall;

  function automatic logic signed [W-1:0] ref_relu(input logic signed [W-1:0] x);
`ifdef FC_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic bit mdl_out_valid();
    return (acc_n / M) > (dr_n / M);
  endfunction

  function automatic bit mdl_in_ready();
    return alive && (((acc_n / M) - (dr_n / M)) < 2);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    bit ev;
    ev = mdl_out_valid();
    check("in_ready", int'(in_ready), int'(mdl_in_ready()));
    check("out_valid", int'(out_valid), int'(ev));
    check("out_last", int'(out_last), int'(ev && ((dr_n % M) == M - 1)));
    check("out_data", int'(out_data), ev ? int'(exp_q[0]) : 0);
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs (just after a falling edge), update the model
  // for the rising edge, then sample outputs at the next falling edge.
  task automatic step(input logic v, input logic signed [W-1:0] d, input logic r);
    bit acc;
    bit drn;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    acc = v && mdl_in_ready();
    drn = r && mdl_out_valid();
    if (acc) begin
      exp_q.push_back(ref_relu(d));
      acc_n++;
      phase_acc++;
    end else if (v) begin
      phase_stall++;
    end
    if (drn) begin
      void'(exp_q.pop_front());
      dr_n++;
    end
    @(negedge clk);
    alive = 1'b1;
    compare();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    exp_q.delete();
    acc_n = 0;
    dr_n  = 0;
    alive = 1'b0;
    compare();
    reset = 1'b0;
  endtask

  // Offer a stream of n elements (value base+k, or random when base < 0),
  // holding each value until accepted. rmode: 0 ready, 1 stalled, 2 toggle,
  // 3 random.
  task automatic stream(input int n, input int base, input int rmode);
    int k;
    int budget;
    logic signed [W-1:0] d;
    logic r;
    k = 0;
    budget = 0;
    phase_acc = 0;
    phase_stall = 0;
    d = (base < 0) ? W'($urandom_range(0, (1 << W) - 1)) : W'(base);
    while (k < n && budget < 40 * n + 100) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'b0;
        2:       r = budget[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      step(1'b1, d, r);
      budget++;
      if (phase_acc > k) begin
        k = phase_acc;
        d = (base < 0) ? W'($urandom_range(0, (1 << W) - 1)) : W'(base + k);
      end
    end
    if (k < n) check("stream_timeout", k, n);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (mdl_out_valid() && budget < 300) begin
      step(1'b0, '0, 1'b1);
      budget++;
    end
    if (mdl_out_valid()) check("drain_timeout", budget, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic signed [W-1:0] rv [M];
    n_checks = 0;
    n_errors = 0;
    acc_n    = 0;
    dr_n     = 0;
    alive    = 1'b0;
    phase_acc = 0;
    phase_stall = 0;

    do_reset();

    // 1..17 with the consumer always ready.
    stream(M, 1, 0);
    drain();
    check("first_frame_drained", dr_n, M);

    // ReLU boundary values, padded with alternating-sign values.
    rv[0] = -14'sd5;
    rv[1] = 14'sd0;
    rv[2] = 14'sd3;
    rv[3] = -14'sd8192;
    rv[4] = 14'sd8191;
    for (int i = 5; i < M; i++) rv[i] = (i % 2 == 0) ? W'(-i) : W'(i);
    phase_acc = 0;
    for (int i = 0; i < M; i++) step(1'b1, rv[i], 1'b0);
    in_valid = 1'b0;
    check("relu_frame_accepts", phase_acc, M);
    drain();

    // Consumer stalled for 40 offers: both banks fill, then back-pressure.
    phase_acc = 0;
    for (int i = 0; i < 40; i++) step(1'b1, W'(100 + i), 1'b0);
    in_valid = 1'b0;
    check("stalled_accepts", phase_acc, 2 * M);
    drain();

    // Continuous flow for five frames: no input stalls.
    stream(5 * M, 200, 0);
    check("cont_stalls", phase_stall, 0);
    drain();

    // Consumer toggling ready every cycle.
    stream(2 * M, 500, 2);
    drain();

    // Partial frame then reset: only the following frame must emerge.
    stream(5, 900, 1);
    do_reset();
    stream(M, 1000, 0);
    drain();
    check("post_reset_drained", dr_n, M);

    // Random traffic on both sides.
    stream(6 * M, -1, 3);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
